// File: rtl/alu_seq.sv
// alu_seq: multi-cycle signed ALU with valid/ready handshake, saturating add/sub
// and an N-cycle shift-add multiplier with a fixed-point product window.
module alu_seq #(
   parameter int N    = 8,
   parameter int FRAC = 7,
   parameter int SAT  = 1
) (
   input  logic         clk,
   input  logic         nReset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   func,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   output logic [N-1:0] result,
   output logic         ovf
);
   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [2:0] F_B = 3'd1, F_ADD = 3'd2, F_MUL = 3'd3, F_SUB = 3'd4;
   localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};
   typedef enum logic {IDLE, MUL} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [2*N-1:0] acc, mcand, mag, prod, hi;
   logic [N-1:0] mplier, abs_a, abs_b, alu_r, mul_r;
   logic [N:0] sum;
   logic neg, arith, alu_o, mul_o, last;
   // |-2^(N-1)| wraps to 2^(N-1), which is still correct read as unsigned
   always_comb begin
      abs_a = a[N-1] ? -a : a;
      abs_b = b[N-1] ? -b : b;
      sum = (func == F_SUB) ? {a[N-1], a} - {b[N-1], b} : {a[N-1], a} + {b[N-1], b};
      arith = (func == F_ADD) || (func == F_SUB);
      alu_o = arith && (sum[N] ^ sum[N-1]);
      alu_r = !arith ? ((func == F_B) ? b : a)
            : (alu_o && SAT != 0) ? (sum[N] ? MIN_V : MAX_V) : sum[N-1:0];
      last = cnt == CW'(N-1);
      mag = acc + (mplier[0] ? mcand : '0);
      prod = neg ? -mag : mag;
      hi = $signed(prod) >>> (FRAC + N - 1);
      mul_o = hi != {(2*N){prod[2*N-1]}};
      mul_r = (mul_o && SAT != 0) ? (prod[2*N-1] ? MIN_V : MAX_V) : prod[FRAC+N-1 -: N];
      in_ready = state == IDLE;
      state_nx = (state == IDLE) ? ((in_valid && func == F_MUL) ? MUL : IDLE)
               : (last ? IDLE : MUL);
   end
   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         neg <= 1'b0;
         out_valid <= 1'b0;
         result <= '0;
         ovf <= 1'b0;
      end else begin
         state <= state_nx;
         out_valid <= 1'b0;
         if (state == IDLE && in_valid) begin
            if (func == F_MUL) begin
               cnt <= '0;
               acc <= '0;
               mcand <= {{N{1'b0}}, abs_a};
               mplier <= abs_b;
               neg <= a[N-1] ^ b[N-1];
            end else begin
               out_valid <= 1'b1;
               result <= alu_r;
               ovf <= alu_o;
            end
         end else if (state == MUL) begin
            acc <= mag;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + CW'(1);
            if (last) begin
               out_valid <= 1'b1;
               result <= mul_r;
               ovf <= mul_o;
            end
         end
      end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: three alu_seq configurations under directed and random stimulus vs an arithmetic model.
module tb_alu_seq;
   logic clk = 1'b0, nReset = 1'b1, in_valid = 1'b0;
   logic [2:0] func = '0;
   logic [7:0] a = '0, b = '0;
   logic rdy [3];
   logic ov [3];
   logic of [3];
   logic [7:0] res [3];
   int errors = 0, checks = 0;
   int m_busy;
   logic m_ov;
   logic [7:0] m_res [3];
   logic m_of [3];
   logic [7:0] pa, pb;
   always #5 clk = ~clk;
   alu_seq #(.N(8), .FRAC(7), .SAT(1)) d0 (.clk(clk), .nReset(nReset), .in_valid(in_valid),
      .in_ready(rdy[0]), .func(func), .a(a), .b(b), .out_valid(ov[0]), .result(res[0]), .ovf(of[0]));
   alu_seq #(.N(8), .FRAC(7), .SAT(0)) d1 (.clk(clk), .nReset(nReset), .in_valid(in_valid),
      .in_ready(rdy[1]), .func(func), .a(a), .b(b), .out_valid(ov[1]), .result(res[1]), .ovf(of[1]));
   alu_seq #(.N(8), .FRAC(8), .SAT(1)) d2 (.clk(clk), .nReset(nReset), .in_valid(in_valid),
      .in_ready(rdy[2]), .func(func), .a(a), .b(b), .out_valid(ov[2]), .result(res[2]), .ovf(of[2]));
   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask
   function automatic int frac_of(int c);
      return (c == 2) ? 8 : 7;
   endfunction
   function automatic bit sat_of(int c);
      return c != 1;
   endfunction
   // {ovf, result} from plain integer arithmetic on the signed operand values
   function automatic logic [8:0] ref_op(logic [2:0] f, logic [7:0] x, logic [7:0] y, int frac, bit sat);
      int sx, sy, v;
      sx = $signed(x);
      sy = $signed(y);
      if (f == 3'd1) return {1'b0, y};
      if (f != 3'd2 && f != 3'd3 && f != 3'd4) return {1'b0, x};
      v = (f == 3'd2) ? sx + sy : (f == 3'd4) ? sx - sy : (sx * sy) >>> frac;
      if (v > 127 || v < -128) return sat ? {1'b1, (v < 0) ? 8'h80 : 8'h7F} : {1'b1, v[7:0]};
      return {1'b0, v[7:0]};
   endfunction
   always @(posedge clk or negedge nReset)
      if (!nReset) begin
         m_busy <= 0;
         m_ov <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            m_res[c] <= '0;
            m_of[c] <= 1'b0;
         end
      end else begin
         m_ov <= 1'b0;
         if (m_busy != 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
               m_ov <= 1'b1;
               for (int c = 0; c < 3; c++) {m_of[c], m_res[c]} <= ref_op(3'd3, pa, pb, frac_of(c), sat_of(c));
            end
         end else if (in_valid) begin
            if (func == 3'd3) begin
               m_busy <= 8;
               pa <= a;
               pb <= b;
            end else begin
               m_ov <= 1'b1;
               for (int c = 0; c < 3; c++) {m_of[c], m_res[c]} <= ref_op(func, a, b, frac_of(c), sat_of(c));
            end
         end
      end
   always @(negedge clk)
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("out_valid[%0d]", c), 16'(ov[c]), 16'(m_ov));
         chk($sformatf("in_ready[%0d]", c), 16'(rdy[c]), 16'(m_busy == 0));
         chk($sformatf("result[%0d]", c), 16'(res[c]), 16'(m_res[c]));
         chk($sformatf("ovf[%0d]", c), 16'(of[c]), 16'(m_of[c]));
      end
   task automatic drive(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
      in_valid = 1'b1;
      func = f;
      a = x;
      b = y;
   endtask
   task automatic idle();
      in_valid = 1'b0;
      func = 3'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
   endtask
   task automatic one_op(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int low);
      @(posedge clk); #1 drive(f, x, y);
      @(posedge clk); #1 idle();
      lat = 0;
      low = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!rdy[0]) low++;
      end while (!ov[0] && lat < 30);
      if (lat >= 30) chk("op_timeout", 16'(0), 16'(1));
   endtask
   function automatic logic [7:0] pick();
      int r;
      r = $urandom_range(0, 7);
      return (r == 0) ? 8'h80 : (r == 1) ? 8'h7F : (r == 2) ? 8'hFF : 8'($urandom);
   endfunction
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int lat, low, n;
      logic [7:0] lastr;
      logic [7:0] e4 [3];
      #1 nReset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_result", 16'(res[0]), 16'h0);
      chk("rst_ovf", 16'(of[0]), 16'h0);
      chk("rst_out_valid", 16'(ov[0]), 16'h0);
      chk("rst_in_ready", 16'(rdy[0]), 16'h1);
      nReset = 1'b1;
      one_op(3'd2, 8'd100, 8'd50, lat, low);
      chk("add_lat", 16'(lat), 16'd1);
      chk("add_sat_res", 16'(res[0]), 16'h7F);
      chk("add_sat_ovf", 16'(of[0]), 16'h1);
      chk("add_wrap_res", 16'(res[1]), 16'h96);
      chk("add_wrap_ovf", 16'(of[1]), 16'h1);
      one_op(3'd3, 8'h40, 8'h40, lat, low);
      chk("mul_lat", 16'(lat), 16'd9);
      chk("mul_busy", 16'(low), 16'd8);
      chk("mul_res", 16'(res[0]), 16'h20);
      chk("mul_ovf", 16'(of[0]), 16'h0);
      one_op(3'd3, 8'hC0, 8'h40, lat, low);
      chk("mul_neg_res", 16'(res[0]), 16'hE0);
      chk("mul_neg_ovf", 16'(of[0]), 16'h0);
      one_op(3'd3, 8'h80, 8'h80, lat, low);
      chk("mul_min_res", 16'(res[0]), 16'h7F);
      chk("mul_min_ovf", 16'(of[0]), 16'h1);
      chk("mul_min_wrap", 16'(res[1]), 16'h80);
      chk("mul_min_f8", 16'(res[2]), 16'h40);
      chk("mul_min_f8_ovf", 16'(of[2]), 16'h0);
      e4[0] = 8'd3;
      e4[1] = 8'h80;
      e4[2] = 8'd5;
      @(posedge clk); #1 drive(3'd2, 8'd1, 8'd2);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k == 0) drive(3'd4, 8'h80, 8'd1);
         else if (k == 1) drive(3'd1, 8'($urandom), 8'd5);
         else idle();
         @(negedge clk);
         chk($sformatf("b2b_valid%0d", k), 16'(ov[0]), 16'h1);
         chk($sformatf("b2b_res%0d", k), 16'(res[0]), 16'(e4[k]));
         chk($sformatf("b2b_ovf%0d", k), 16'(of[0]), 16'(k == 1));
      end
      @(posedge clk); #1 drive(3'd3, 8'h40, 8'h40);
      @(posedge clk); #1 drive(3'd2, 8'd7, 8'd7);
      n = 0;
      lastr = '0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (ov[0]) begin
            n++;
            lastr = res[0];
         end
         if (rdy[0] && in_valid) begin
            @(posedge clk); #1 idle();
         end
      end
      chk("hold_count", 16'(n), 16'd2);
      chk("hold_res", 16'(lastr), 16'd14);
      @(posedge clk); #1 drive(3'd3, 8'h40, 8'h40);
      @(posedge clk); #1 idle();
      repeat (4) @(posedge clk);
      #1 nReset = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 16'(ov[0]), 16'h0);
      chk("midrst_res", 16'(res[0]), 16'h0);
      chk("midrst_ovf", 16'(of[0]), 16'h0);
      chk("midrst_ready", 16'(rdy[0]), 16'h1);
      nReset = 1'b1;
      one_op(3'd3, 8'h40, 8'h40, lat, low);
      chk("post_rst_mul", 16'(res[0]), 16'h20);
      chk("post_rst_lat", 16'(lat), 16'd9);
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         nReset = $urandom_range(0, 149) != 0;
         in_valid = $urandom_range(0, 3) != 0;
         func = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
      end
      @(posedge clk); #1 nReset = 1'b1;
      idle();
      repeat (12) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
